simd_dp_acc: RTL and testbench

Pipelined, parametrised SIMD dot-product engine with multi-beat accumulation. It is the successor to the combinational GEMM dot-product path and sits in the EX stage behind the operand registers. Each beat multiplies two W-bit operand vectors lane-wise at int16/int8/int4/int2 precision, signed or unsigned, and reduces the lane products to one sum. Sums accumulate over a burst of beats delimited by a last flag, and the result is returned on a valid/ready interface.

---
 rtl/simd_dp_acc.sv | 216 +++++++++++++++++++++
 tb/tb_simd_dp_acc.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/simd_dp_acc.sv
// SIMD dot-product engine: lane-wise int16/8/4/2 multiply, per-beat reduction,
// multi-beat accumulation with sticky overflow, valid/ready result port.

// One 16-bit slice of the operands: products of all elements in the slice,
// already reduced to a single signed partial sum for the selected precision.
module simd_dp_lane (
    input  logic [1:0]         mode,
    input  logic               sgn,
    input  logic [15:0]        a,
    input  logic [15:0]        b,
    output logic signed [32:0] sum
);
    logic signed [33:0] p16;
    logic signed [17:0] p8;
    logic signed [9:0]  p4;
    logic signed [5:0]  p2;

    // Sign- or zero-extend each element by one bit, multiply, and sum the slice
    always_comb begin
        sum = '0;
        p16 = '0;
        p8  = '0;
        p4  = '0;
        p2  = '0;
        case (mode)
            2'b00: begin
                p16 = 34'(signed'({sgn & a[15], a})) * 34'(signed'({sgn & b[15], b}));
                sum = p16[32:0];
            end
            2'b01: begin
                for (int j = 0; j < 2; j++) begin
                    p8  = 18'(signed'({sgn & a[8*j+7], a[8*j +: 8]}))
                        * 18'(signed'({sgn & b[8*j+7], b[8*j +: 8]}));
                    sum = sum + 33'(p8);
                end
            end
            2'b10: begin
                for (int j = 0; j < 4; j++) begin
                    p4  = 10'(signed'({sgn & a[4*j+3], a[4*j +: 4]}))
                        * 10'(signed'({sgn & b[4*j+3], b[4*j +: 4]}));
                    sum = sum + 33'(p4);
                end
            end
            default: begin
                for (int j = 0; j < 8; j++) begin
                    p2  = 6'(signed'({sgn & a[2*j+1], a[2*j +: 2]}))
                        * 6'(signed'({sgn & b[2*j+1], b[2*j +: 2]}));
                    sum = sum + 33'(p2);
                end
            end
        endcase
    end
endmodule

module simd_dp_acc #(
    parameter int W     = 64,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [1:0]       mode,
    input  logic             signed_en,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [1:0]       out_mode,
    output logic             busy
);
    localparam int NCH = W / 16;

    logic             en, fire, first, in_progress;
    logic [1:0]       mode_lat, eff_mode;
    logic             sgn_lat, eff_sgn;
    logic [NCH-1:0][32:0] chunk_sum;

    // vld_pipe[1] = S1 holds a beat, vld_pipe[2] = S2 holds a beat
    logic [2:1]           vld_pipe;
    logic                 s1_first, s1_last, s1_sgn;
    logic [1:0]           s1_mode;
    logic [NCH-1:0][32:0] s1_sum;
    logic                 s2_first, s2_last, s2_sgn;
    logic [1:0]           s2_mode;
    logic [ACC_W-1:0]     s2_sum, beat_sum;

    logic [ACC_W-1:0]     acc, new_acc;
    logic                 ovf_acc, new_ovf, step_ovf;
    logic [ACC_W:0]       add_full;

    // A pending, unconsumed result freezes the whole pipe
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign fire     = in_valid && en;
    assign first    = !in_progress;
    assign eff_mode = first ? mode : mode_lat;
    assign eff_sgn  = first ? signed_en : sgn_lat;
    assign busy     = in_progress || (|vld_pipe);

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        simd_dp_lane u_lane (
            .mode (eff_mode),
            .sgn  (eff_sgn),
            .a    (a_in[16*k +: 16]),
            .b    (b_in[16*k +: 16]),
            .sum  (chunk_sum[k])
        );
    end

    // Burst tracking: precision and signedness are frozen on the first beat
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            in_progress <= 1'b0;
            mode_lat    <= 2'b00;
            sgn_lat     <= 1'b0;
        end else if (fire) begin
            in_progress <= !in_last;
            if (first) begin
                mode_lat <= mode;
                sgn_lat  <= signed_en;
            end
        end
    end

    // S1: register the per-slice product sums and beat attributes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_pipe[1] <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_sgn      <= 1'b0;
            s1_mode     <= 2'b00;
            s1_sum      <= '0;
        end else if (en) begin
            vld_pipe[1] <= fire;
            if (fire) begin
                s1_first <= first;
                s1_last  <= in_last;
                s1_sgn   <= eff_sgn;
                s1_mode  <= eff_mode;
                s1_sum   <= chunk_sum;
            end
        end
    end

    // Reduce slice sums to one beat sum, sign-extended to the accumulator width
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < NCH; k++)
            beat_sum = beat_sum + {{(ACC_W-33){s1_sum[k][32]}}, s1_sum[k]};
    end

    // S2: register the beat sum ahead of the accumulator
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_pipe[2] <= 1'b0;
            s2_first    <= 1'b0;
            s2_last     <= 1'b0;
            s2_sgn      <= 1'b0;
            s2_mode     <= 2'b00;
            s2_sum      <= '0;
        end else if (en) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_sgn   <= s1_sgn;
                s2_mode  <= s1_mode;
                s2_sum   <= beat_sum;
            end
        end
    end

    // Next accumulator value and sticky overflow (carry-out or signed overflow)
    always_comb begin
        add_full = {1'b0, acc} + {1'b0, s2_sum};
        if (s2_sgn)
            step_ovf = (acc[ACC_W-1] == s2_sum[ACC_W-1]) && (add_full[ACC_W-1] != acc[ACC_W-1]);
        else
            step_ovf = add_full[ACC_W];
        new_acc = s2_first ? s2_sum : add_full[ACC_W-1:0];
        new_ovf = s2_first ? 1'b0 : (ovf_acc | step_ovf);
    end

    // Accumulator register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (en && vld_pipe[2]) begin
            acc     <= new_acc;
            ovf_acc <= new_ovf;
        end
    end

    // Result register: load on the last beat, otherwise drop after handshake
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_mode  <= 2'b00;
        end else if (en && vld_pipe[2] && s2_last) begin
            out_valid <= 1'b1;
            out_data  <= new_acc;
            out_ovf   <= new_ovf;
            out_mode  <= s2_mode;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_simd_dp_acc.sv
// Directed bench for simd_dp_acc: a table of single-beat bursts plus
// hand-written multi-beat, back-to-back, stall, overflow and reset sequences.
// A second instance with ACC_W=36 shares the inputs for the overflow checks.
module tb_simd_dp_acc;
    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid, in_last, signed_en, out_ready;
    logic [1:0]  mode;
    logic [63:0] a_in, b_in;

    logic        in_ready, out_valid, out_ovf, busy;
    logic [47:0] out_data;
    logic [1:0]  out_mode;

    logic        in_ready36, out_valid36, out_ovf36, busy36;
    logic [35:0] out_data36;
    logic [1:0]  out_mode36;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    simd_dp_acc #(.W(64), .ACC_W(48)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .mode(mode), .signed_en(signed_en),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_mode(out_mode), .busy(busy)
    );

    simd_dp_acc #(.W(64), .ACC_W(36)) dut36 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready36),
        .in_last(in_last), .mode(mode), .signed_en(signed_en),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid36), .out_ready(out_ready),
        .out_data(out_data36), .out_ovf(out_ovf36), .out_mode(out_mode36), .busy(busy36)
    );

    typedef struct {
        logic [1:0]  m;
        logic        s;
        logic [63:0] a;
        logic [63:0] b;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic s, input logic [63:0] a,
                         input logic [63:0] b, input logic l);
        @(negedge clk);
        in_valid = 1'b1; mode = m; signed_en = s; a_in = a; b_in = b; in_last = l;
    endtask

    // Drops in_valid after the last driven beat, then waits (bounded) for a result
    task automatic get_result(input string name, output logic [47:0] d, output logic ov,
                              output logic [1:0] m, output logic [35:0] d36,
                              output logic ov36, output int lat);
        logic found;
        found = 1'b0;
        lat = 0;
        while (!found && lat < 16) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            lat++;
            if (out_valid) found = 1'b1;
        end
        chk({name, "_arrived"}, 64'(found), 64'd1);
        d = out_data; ov = out_ovf; m = out_mode; d36 = out_data36; ov36 = out_ovf36;
    endtask

    logic [47:0] d;
    logic [35:0] d36;
    logic        ov, ov36;
    logic [1:0]  m;
    int          lat;

    localparam logic [63:0] ONES = {64{1'b1}};

    initial begin
        // single-beat bursts with hand-computed results
        vecs[0] = '{2'b00, 1'b1, {4{16'hFFFF}}, {4{16'h0002}}, 48'hFFFF_FFFF_FFF8}; // 4 x (-1*2)
        vecs[1] = '{2'b11, 1'b1, ONES, ONES, 48'd32};                                // 32 x (-1*-1)
        vecs[2] = '{2'b10, 1'b0, ONES, ONES, 48'd3600};                              // 16 x 225
        vecs[3] = '{2'b01, 1'b1, {8{8'hFF}}, {8{8'h01}}, 48'hFFFF_FFFF_FFF8};        // 8 x (-1)
        vecs[4] = '{2'b00, 1'b0, ONES, ONES, 48'd17179344900};                       // 4 x 65535^2
        vecs[5] = '{2'b01, 1'b1, {8{8'h80}}, {8{8'h80}}, 48'd131072};                // 8 x 16384
        vecs[6] = '{2'b10, 1'b1, {16{4'h8}}, {16{4'h7}}, 48'hFFFF_FFFF_FC80};        // 16 x (-56)
        vecs[7] = '{2'b11, 1'b1, {32{2'b10}}, {32{2'b10}}, 48'd128};                 // 32 x 4

        nrst = 1'b0; in_valid = 1'b0; in_last = 1'b0; mode = 2'b00; signed_en = 1'b0;
        a_in = '0; b_in = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("rst_out_mode",  64'(out_mode),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].b, 1'b1);
            get_result($sformatf("vec%0d", i), d, ov, m, d36, ov36, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_mode", i), 64'(m), 64'(vecs[i].m));
            chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'd0);
        end

        // three int2 unsigned beats: 3 x 32 lanes x 9
        drive(2'b11, 1'b0, ONES, ONES, 1'b0);
        drive(2'b11, 1'b0, ONES, ONES, 1'b0);
        @(negedge clk);
        chk("burst_busy", 64'(busy), 64'd1);
        in_valid = 1'b1; in_last = 1'b1;
        get_result("int2_burst", d, ov, m, d36, ov36, lat);
        chk("int2_burst_data", 64'(d), 64'd864);
        chk("int2_burst_mode", 64'(m), 64'd3);

        // back-to-back single-beat bursts: results on consecutive cycles
        drive(2'b10, 1'b0, ONES, ONES, 1'b1);
        drive(2'b01, 1'b1, {8{8'hFF}}, {8{8'h01}}, 1'b1);
        get_result("b2b_first", d, ov, m, d36, ov36, lat);
        chk("b2b_first_data", 64'(d), 64'd3600);
        chk("b2b_first_mode", 64'(m), 64'd2);
        @(negedge clk);
        chk("b2b_second_valid", 64'(out_valid), 64'd1);
        chk("b2b_second_data", 64'(out_data), 64'hFFFF_FFFF_FFF8);
        chk("b2b_second_mode", 64'(out_mode), 64'd1);

        // mode/signedness changed mid-burst must be ignored: 2 x 8 x (2*3)
        drive(2'b01, 1'b0, {8{8'h02}}, {8{8'h03}}, 1'b0);
        drive(2'b00, 1'b1, {8{8'h02}}, {8{8'h03}}, 1'b1);
        get_result("mode_lock", d, ov, m, d36, ov36, lat);
        chk("mode_lock_data", 64'(d), 64'd96);
        chk("mode_lock_mode", 64'(m), 64'd1);

        // stall: X=12, Y=8, Z=32 in flight, W=288 held while output blocked
        @(negedge clk);
        out_ready = 1'b0;
        drive(2'b00, 1'b0, {4{16'h0001}}, {4{16'h0003}}, 1'b1);
        drive(2'b01, 1'b0, {8{8'h01}}, {8{8'h01}}, 1'b1);
        drive(2'b10, 1'b0, {16{4'h1}}, {16{4'h2}}, 1'b1);
        drive(2'b11, 1'b0, ONES, ONES, 1'b1);
        chk("stall_x_data", 64'(out_data), 64'd12);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_in_ready%0d", i), 64'(in_ready), 64'd0);
            chk($sformatf("stall_valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("stall_data%0d", i), 64'(out_data), 64'd12);
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("release_y_valid", 64'(out_valid), 64'd1);
        chk("release_y_data", 64'(out_data), 64'd8);
        @(negedge clk);
        chk("release_z_data", 64'(out_data), 64'd32);
        @(negedge clk);
        chk("release_w_valid", 64'(out_valid), 64'd1);
        chk("release_w_data", 64'(out_data), 64'd288);
        @(negedge clk);
        chk("release_idle", 64'(out_valid), 64'd0);

        // overflow: 5 beats of int16 unsigned 4 x 65535^2 each
        for (int i = 0; i < 5; i++) drive(2'b00, 1'b0, ONES, ONES, i == 4);
        get_result("ovf5", d, ov, m, d36, ov36, lat);
        chk("ovf5_data36", 64'(d36), 64'd17177247764);
        chk("ovf5_ovf36", 64'(ov36), 64'd1);
        chk("ovf5_data48", 64'(d), 64'd85896724500);
        chk("ovf5_ovf48", 64'(ov), 64'd0);
        for (int i = 0; i < 4; i++) drive(2'b00, 1'b0, ONES, ONES, i == 3);
        get_result("acc4", d, ov, m, d36, ov36, lat);
        chk("acc4_data36", 64'(d36), 64'd68717379600);
        chk("acc4_ovf36", 64'(ov36), 64'd0);

        // reset mid-burst, then a fresh single-beat burst must be clean
        drive(2'b00, 1'b0, ONES, ONES, 1'b0);
        drive(2'b00, 1'b0, ONES, ONES, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        nrst = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        drive(2'b01, 1'b1, {8{8'hFF}}, {8{8'h01}}, 1'b1);
        get_result("post_rst", d, ov, m, d36, ov36, lat);
        chk("post_rst_data", 64'(d), 64'hFFFF_FFFF_FFF8);
        chk("post_rst_mode", 64'(m), 64'd1);
        chk("post_rst_ovf", 64'(ov), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
